// File: rtl/spi_apb_cmd_sequencer.sv
// Two-requester round-robin APB master that turns each granted command into one
// SETUP/ACCESS transfer and reports completion on a one-cycle response pulse.
module spi_apb_cmd_sequencer #(
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              psel_d, penable_d, pwrite_d, busy_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rdata_d;
  logic              rsp0_valid_d, rsp1_valid_d, rsp_err_d, rsp_fire;
  logic              grant, handshake, timeout_hit;

  // A lone valid wins outright; on a tie the pointer picks.
  assign grant      = (req0_valid ^ req1_valid) ? req1_valid : ptr_q;
  assign req0_ready = !preset && (state_q == StIdle) && !grant;
  assign req1_ready = !preset && (state_q == StIdle) && grant;
  assign handshake  = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    psel_d    = 1'b0;
    penable_d = 1'b0;
    paddr_d   = paddr;
    pwrite_d  = pwrite;
    pwdata_d  = pwdata;
    rsp_fire  = 1'b0;
    rsp_err_d = 1'b0;
    rdata_d   = '0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (handshake) begin
          id_d     = grant;
          ptr_d    = ~grant;
          paddr_d  = grant ? req1_addr  : req0_addr;
          pwrite_d = grant ? req1_write : req0_write;
          pwdata_d = grant ? req1_wdata : req0_wdata;
          psel_d   = 1'b1;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = StAccess;
      end
      StAccess: begin
        cnt_d = cnt_inc;
        if (pready) begin
          rsp_fire  = 1'b1;
          rsp_err_d = pslverr;
          // Writes and slave errors return zero data.
          rdata_d   = (pwrite || pslverr) ? '0 : prdata;
          state_d   = StResp;
        end else if (timeout_hit) begin
          rsp_fire  = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = StResp;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end
      StResp: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    rsp0_valid_d = rsp_fire && !id_q;
    rsp1_valid_d = rsp_fire && id_q;
    busy_d       = (state_d != StIdle);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= StIdle;
      ptr_q      <= 1'b0;
      id_q       <= 1'b0;
      cnt_q      <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      paddr      <= '0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      psel       <= psel_d;
      penable    <= penable_d;
      paddr      <= paddr_d;
      pwrite     <= pwrite_d;
      pwdata     <= pwdata_d;
      rsp0_valid <= rsp0_valid_d;
      rsp0_rdata <= rsp0_valid_d ? rdata_d : '0;
      rsp0_err   <= rsp0_valid_d && rsp_err_d;
      rsp1_valid <= rsp1_valid_d;
      rsp1_rdata <= rsp1_valid_d ? rdata_d : '0;
      rsp1_err   <= rsp1_valid_d && rsp_err_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_spi_apb_cmd_sequencer.sv
// Directed plus randomized bench for spi_apb_cmd_sequencer; expected values come
// from a transaction-level model of arbitration and response rules.
module tb_spi_apb_cmd_sequencer;

  logic       pclk = 1'b0;
  logic       preset;
  logic       req0_valid, req0_ready, req0_write;
  logic [2:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       rsp0_valid, rsp0_err;
  logic [7:0] rsp0_rdata;
  logic       req1_valid, req1_ready, req1_write;
  logic [2:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       rsp1_valid, rsp1_err;
  logic [7:0] rsp1_rdata;
  logic [2:0] paddr;
  logic       psel, penable, pwrite, pready, pslverr, busy;
  logic [7:0] pwdata, prdata;

  int total = 0;
  int bad   = 0;
  bit tie_pref = 1'b0;  // requester that wins the next tie

  spi_apb_cmd_sequencer #(
    .ADDR_W(3), .DATA_W(8), .TIMEOUT_CYCLES(16), .CNT_W(5)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete command from IDLE back to IDLE with all phases checked.
  task automatic txn(input bit v0, input bit v1, input bit wr,
                     input logic [2:0] a0, input logic [2:0] a1,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input int waits, input logic [7:0] rd, input bit serr, input bit tmo);
    bit         g, eerr;
    logic [2:0] ea;
    logic [7:0] ed, erd;
    g    = (v0 && !v1) ? 1'b0 : ((v1 && !v0) ? 1'b1 : tie_pref);
    ea   = g ? a1 : a0;
    ed   = g ? d1 : d0;
    eerr = tmo || serr;
    erd  = (wr || eerr) ? 8'h00 : rd;
    req0_valid = v0; req1_valid = v1;
    req0_write = wr; req1_write = wr;
    req0_addr  = a0; req1_addr  = a1;
    req0_wdata = d0; req1_wdata = d1;
    pready = 1'b0; pslverr = 1'b0;
    #1;
    chk("ready0", req0_ready, !g);
    chk("ready1", req1_ready, g);
    chk("busy_idle", busy, 0);
    tie_pref = !g;
    tick();
    // Scramble request fields: the transfer must use the handshake snapshot.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_write = !wr; req1_write = !wr;
    req0_addr  = 3'($urandom); req1_addr  = 3'($urandom);
    req0_wdata = 8'($urandom); req1_wdata = 8'($urandom);
    #1;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, ea);
    chk("setup_pwdata", pwdata, ed);
    chk("setup_pwrite", pwrite, wr);
    chk("setup_busy", busy, 1);
    tick();
    if (tmo) begin
      for (int i = 0; i < 16; i++) begin
        #1;
        chk("tmo_access", {psel, penable}, 2'b11);
        tick();
      end
    end else begin
      for (int i = 0; i < waits; i++) begin
        #1;
        chk("wait_access", {psel, penable}, 2'b11);
        chk("wait_paddr", paddr, ea);
        tick();
      end
      pready = 1'b1; prdata = rd; pslverr = serr;
      #1;
      chk("access", {psel, penable}, 2'b11);
      tick();
    end
    pready = 1'b0; pslverr = 1'b0; prdata = 8'($urandom);
    #1;
    chk("resp_psel", {psel, penable}, 2'b00);
    chk("resp_valid", {rsp1_valid, rsp0_valid}, g ? 2'b10 : 2'b01);
    chk("resp_rdata", g ? rsp1_rdata : rsp0_rdata, erd);
    chk("resp_err", g ? rsp1_err : rsp0_err, eerr);
    tick();
    #1;
    chk("post_resp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("post_resp_busy", busy, 0);
  endtask

  initial begin
    preset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_write = 1'b0; req1_write = 1'b0;
    req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick();
    tick();
    chk("rst_ready0", req0_ready, 0);
    chk("rst_psel", {psel, penable}, 2'b00);
    chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 4'b0000);
    chk("rst_rdata", {rsp0_rdata, rsp1_rdata}, 16'h0000);
    chk("rst_busy", busy, 0);
    preset = 1'b0;
    #1;
    chk("rel_ready0", req0_ready, 1);

    // Directed write, then read with three wait states.
    txn(1, 0, 1, 3'd0, 3'd7, 8'h51, 8'hEE, 0, 8'h00, 0, 0);
    txn(0, 1, 0, 3'd2, 3'd5, 8'h11, 8'h22, 3, 8'hAA, 0, 0);

    // Tied requests alternate starting with req0.
    for (int i = 0; i < 4; i++)
      txn(1, 1, 1'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
          int'($urandom_range(0, 2)), 8'($urandom), 0, 0);

    // Slave error on a write, then watchdog abort on a read.
    txn(1, 0, 1, 3'd3, 3'd1, 8'h5A, 8'h00, 1, 8'h00, 1, 0);
    txn(0, 1, 0, 3'd4, 3'd6, 8'h00, 8'h00, 0, 8'h00, 0, 1);

    // Reset mid-ACCESS: abandoned, no response, pointer returns to req0.
    req0_valid = 1'b1; req1_valid = 1'b0;
    tick();
    req0_valid = 1'b0;
    tick();
    #1;
    chk("mid_access", {psel, penable}, 2'b11);
    preset = 1'b1;
    tick();
    chk("mid_rst_psel", {psel, penable}, 2'b00);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
    preset = 1'b0;
    tick();
    chk("mid_rst_norsp", {rsp0_valid, rsp1_valid}, 2'b00);
    tie_pref = 1'b0;
    txn(1, 1, 0, 3'd1, 3'd2, 8'h00, 8'h00, 0, 8'h3C, 0, 0);

    // Randomized commands; slave errors only on writes.
    for (int i = 0; i < 20; i++) begin
      bit rv0, rv1, rwr;
      rv0 = 1'($urandom);
      rv1 = rv0 ? 1'($urandom) : 1'b1;
      rwr = 1'($urandom);
      txn(rv0, rv1, rwr, 3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
          int'($urandom_range(0, 4)), 8'($urandom), rwr && ($urandom_range(0, 3) == 0), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_apb_cmd_sequencer.md
Name: spi_apb_cmd_sequencer

Overview:
APB master that sequences register transfers into the SPI APB slave (control, baud, status and data registers). It arbitrates between two command requesters (req0: host/config, req1: data streamer) using round-robin. Each granted command is turned into one APB setup/access transfer. Completion is reported on the requester's response port, together with read data and an error flag. A watchdog aborts transfers whose pready never arrives.

Parameters:
ADDR_W, 3, APB/command address width
DATA_W, 8, APB/command data width
TIMEOUT_CYCLES, 16, max ACCESS-phase cycles before abort; 0 = timeout disabled
CNT_W, 5, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
pclk  in  1  clock, all logic on rising edge
preset  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle
req0_write  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  register address
req0_wdata  in  DATA_W  write data
rsp0_valid  out  1  one-cycle completion pulse for requester 0
rsp0_rdata  out  DATA_W  read data (0 for writes/errors)
rsp0_err  out  1  pslverr or timeout
req1_valid, req1_ready, req1_write, req1_addr, req1_wdata  same as req0, for requester 1
rsp1_valid, rsp1_rdata, rsp1_err  same as rsp0, for requester 1
paddr  out  ADDR_W  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (preset=1 at a rising edge):
  - State returns to IDLE; round-robin pointer selects req0 first.
  - All registered outputs clear to 0: paddr, psel, penable, pwrite, pwdata, rsp*_valid, rsp*_rdata, rsp*_err, busy.
  - req*_ready is forced to 0 while preset=1.
  - A reset during SETUP or ACCESS abandons the transfer. psel/penable are 0 after that edge, and no response is issued.
- FSM states:
  - IDLE: reqX_ready = (state==IDLE) && grant==X. These are combinational, and only one is ever high.
    - Grant rule: if only one valid, grant it. If both valid, grant the requester the pointer selects.
    - On handshake (valid & ready): latch write/addr/wdata and the requester id, and flip the pointer to the other requester. Next state SETUP.
  - SETUP: psel=1, penable=0; paddr/pwrite/pwdata driven from the latch and held stable until exit. Next state ACCESS unconditionally.
  - ACCESS: psel=1, penable=1; timeout counter increments each cycle.
    - On pready=1: capture prdata (reads only; writes store 0) and pslverr. Next state RESP.
    - Else, if TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES: abort with err=1, rdata=0. Next state RESP.
    - pready has priority over timeout when both occur in the same cycle.
  - RESP: psel=penable=0. rspX_valid=1 for exactly one cycle on the latched requester, with rdata/err. Next state IDLE; counter cleared.
- Latency with pready tied 1: handshake at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3. The next handshake can occur at N+4.
- There is no response backpressure; requesters must sample rsp on the pulse.
- Request fields are sampled only at handshake; later changes do not affect the transfer in flight.
- busy = (state != IDLE).

Test Plan:
- Reset: hold preset=1 for 2 cycles while req0_valid=1 -> req0_ready=0, psel=penable=0, all rsp 0; req0 granted on the first cycle after release.
- Write: req0 write addr=0 wdata=0x51, pready=1 -> SETUP at N+1 with paddr=0, pwdata=0x51, pwrite=1; penable=1 at N+2; rsp0_valid=1, err=0, rdata=0 at N+3.
- Read with wait states: req1 read addr=5, pready asserted after 3 ACCESS cycles with prdata=0xAA -> psel/penable held throughout; rsp1_valid=1, rsp1_rdata=0xAA, err=0.
- Arbitration: req0_valid and req1_valid both held high for 4 commands -> grants in order 0,1,0,1; never two ready pulses in the same cycle.
- Errors: pready=1 with pslverr=1 -> rsp err=1. Separately, pready held 0 with TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles, rsp err=1, rdata=0, psel drops in RESP.
- Reset mid-ACCESS: assert preset during ACCESS -> psel=penable=0 on the next edge, no rsp pulse, state IDLE, pointer back to req0.
